posicionador_embarcacao: RTL and testbench
==========================================

Name: posicionador_embarcacao

Overview:
- Upstream stage of the per-ship VGA renderers. Lets a player place one ship of fixed length on the 8x8 map by moving and rotating a cursor, then confirming the placement.
- Checks the ship against cells already occupied by other ships.
- Produces the 64-bit packed coordinate vector the renderer consumes, plus an occupancy bitmap of the ship's own cells.

Parameters:
- COMPRIMENTO, 5, ship length in cells; legal range 2..5.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- iniciar  in  1  single-cycle pulse; starts or restarts placement
- btnCima  in  1  single-cycle pulse; Y+1
- btnBaixo  in  1  single-cycle pulse; Y-1
- btnDireita  in  1  single-cycle pulse; X+1
- btnEsquerda  in  1  single-cycle pulse; X-1
- btnGirar  in  1  single-cycle pulse; toggle horizontal/vertical
- btnConfirma  in  1  single-cycle pulse; request commit
- mapaOcupado  in  64  occupied cells; bit (Y-1)*8+(X-1)
- posicoesEmbarcacao  out  64  packed ship coordinates, registered
- ocupacaoNova  out  64  this ship's cells, same indexing as mapaOcupado, registered
- valido  out  1  ship is visible (PLACING, CHECK or DONE)
- pronto  out  1  placement committed
- erro  out  1  one-cycle pulse on a rejected commit

Behaviour:
- Button pulses arrive debounced and synchronised; one pulse is one command.
- Reset (asynchronous): FSM=IDLE, anchor=(1,1), horizontal; every output is 0.
- Packing:
  - bits[2:0] = COMPRIMENTO.
  - Cell i (0..COMPRIMENTO-1): X in [6+8i -:4], Y in [10+8i -:4].
  - Cells i>=COMPRIMENTO and bits[63:43] are 0.
- Cell geometry:
  - Horizontal: cell i = (AX+i, AY).
  - Vertical: cell i = (AX, AY+i).
  - Coordinates are 1..8 in 4 bits.
- Bounds:
  - Horizontal: AX<=9-COMPRIMENTO.
  - Vertical: AY<=9-COMPRIMENTO.
  - All anchors >=1.
  - A move or rotate that would violate a bound is ignored; no clamping.
- FSM states:
  - IDLE: outputs 0. iniciar -> PLACING with anchor (1,1), horizontal.
  - PLACING: apply at most one command per cycle. Priority: btnConfirma > btnGirar > btnCima > btnBaixo > btnDireita > btnEsquerda; lower-priority pulses in the same cycle are dropped. btnConfirma -> CHECK. iniciar -> restart at (1,1) horizontal and has priority over every button.
  - CHECK: one cycle. Compute ocupacaoNova & mapaOcupado. If nonzero: erro=1 for this cycle, return to PLACING with anchor unchanged. If zero: -> DONE.
  - DONE: pronto=1; vector and bitmap frozen; buttons ignored. iniciar -> PLACING at (1,1) horizontal, pronto=0.
- In CHECK, all buttons and iniciar are ignored.
- Latency:
  - posicoesEmbarcacao and ocupacaoNova are updated on the same clock edge that samples the command. The new value is visible in the following cycle.
  - erro is asserted in the CHECK cycle, the cycle after the btnConfirma edge.
  - pronto rises the cycle after CHECK.
- mapaOcupado is sampled only in CHECK. Changes to it in other states have no effect.
- Reset asserted mid-operation (any state) takes effect immediately: IDLE, all outputs 0.

Optional Feature:
- Macro PLACER_ROTATE_EN.
- Defined: btnGirar toggles orientation, subject to the bounds check.
- Undefined: btnGirar is ignored; the ship is always horizontal; orientation logic and the vertical bounds path are not synthesised.

Test Plan:
- COMPRIMENTO=5; reset, then iniciar -> next cycle posicoesEmbarcacao=64'h0000_00A8_A098_908D, ocupacaoNova=64'h1F, valido=1, pronto=0.
- Three btnDireita pulses -> anchor X=4, ocupacaoNova=64'hF8. A fourth btnDireita -> outputs unchanged (bound reached).
- Anchor (1,1), btnGirar (macro defined) -> posicoesEmbarcacao=64'h0000_028A_0989_088D, ocupacaoNova=64'h0000_0001_0101_0101. Same stimulus with the macro undefined -> outputs unchanged.
- Anchor (1,1) horizontal, mapaOcupado=64'h4, btnConfirma -> erro=1 for exactly one cycle, state returns to PLACING, pronto stays 0. Then btnCima and btnConfirma with mapaOcupado=64'h4 -> pronto=1, ocupacaoNova=64'h1F00.
- btnDireita and btnCima in the same cycle from (1,1) -> only the Y move applies, giving anchor (1,2).
- In PLACING, assert reset between clock edges -> all outputs 0 immediately, without waiting for a clock. After release, iniciar -> vector 64'h0000_00A8_A098_908D again.

Source files
------------

// File: rtl/posicionador_embarcacao.sv
// Ship placer: moves/rotates a fixed-length ship on the 8x8 map, checks it against occupied cells and commits it.
// Optional PLACER_ROTATE_EN enables btnGirar; without it the ship is always horizontal.
module posicionador_embarcacao #(
  parameter int unsigned COMPRIMENTO = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        iniciar,
  input  logic        btnCima,
  input  logic        btnBaixo,
  input  logic        btnDireita,
  input  logic        btnEsquerda,
  input  logic        btnGirar,
  input  logic        btnConfirma,
  input  logic [63:0] mapaOcupado,
  output logic [63:0] posicoesEmbarcacao,
  output logic [63:0] ocupacaoNova,
  output logic        valido,
  output logic        pronto,
  output logic        erro
);

  typedef enum logic [1:0] {IDLE, PLACING, CHECK, DONE} estado_t;

  // Highest legal anchor along the ship's long axis.
  localparam logic [3:0] MAXA = 4'(9 - COMPRIMENTO);

  estado_t    state;
  logic [3:0] ax, ay, nAx, nAy;
  logic       hit;

`ifdef PLACER_ROTATE_EN
  logic vert, nVert;
`else
  localparam logic vert  = 1'b0;
  localparam logic nVert = 1'b0;
`endif

  function automatic logic [63:0] packPos(input logic [3:0] x, input logic [3:0] y, input logic v);
    logic [63:0] r;
    r      = '0;
    r[2:0] = 3'(COMPRIMENTO);
    for (int unsigned i = 0; i < COMPRIMENTO; i++) begin
      r[6 + 8*i -: 4]  = v ? x : x + 4'(i);
      r[10 + 8*i -: 4] = v ? y + 4'(i) : y;
    end
    return r;
  endfunction

  function automatic logic [63:0] packOcc(input logic [3:0] x, input logic [3:0] y, input logic v);
    logic [63:0] r;
    logic [3:0]  cx, cy;
    r = '0;
    for (int unsigned i = 0; i < COMPRIMENTO; i++) begin
      cx = v ? x : x + 4'(i);
      cy = v ? y + 4'(i) : y;
      r[{3'(cy - 4'd1), 3'(cx - 4'd1)}] = 1'b1;
    end
    return r;
  endfunction

  assign hit  = |(ocupacaoNova & mapaOcupado);
  assign erro = (state == CHECK) && hit;

  // Only the highest-priority pending command is tried; if it breaks a bound nothing moves.
  always_comb begin
    nAx = ax;
    nAy = ay;
`ifdef PLACER_ROTATE_EN
    nVert = vert;
`endif
    if (iniciar && state != CHECK) begin
      nAx = 4'd1;
      nAy = 4'd1;
`ifdef PLACER_ROTATE_EN
      nVert = 1'b0;
`endif
    end else if (state == PLACING && !btnConfirma) begin
`ifdef PLACER_ROTATE_EN
      if (btnGirar) begin
        if (vert ? (ax <= MAXA) : (ay <= MAXA)) nVert = !vert;
      end else
`endif
      if (btnCima) begin
        if (vert ? (ay < MAXA) : (ay < 4'd8)) nAy = ay + 4'd1;
      end else if (btnBaixo) begin
        if (ay > 4'd1) nAy = ay - 4'd1;
      end else if (btnDireita) begin
        if (vert ? (ax < 4'd8) : (ax < MAXA)) nAx = ax + 4'd1;
      end else if (btnEsquerda) begin
        if (ax > 4'd1) nAx = ax - 4'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state              <= IDLE;
      ax                 <= 4'd1;
      ay                 <= 4'd1;
`ifdef PLACER_ROTATE_EN
      vert               <= 1'b0;
`endif
      posicoesEmbarcacao <= '0;
      ocupacaoNova       <= '0;
      valido             <= 1'b0;
      pronto             <= 1'b0;
    end else begin
      ax <= nAx;
      ay <= nAy;
`ifdef PLACER_ROTATE_EN
      vert <= nVert;
`endif
      case (state)
        IDLE: begin
          if (iniciar) begin
            state              <= PLACING;
            valido             <= 1'b1;
            posicoesEmbarcacao <= packPos(nAx, nAy, nVert);
            ocupacaoNova       <= packOcc(nAx, nAy, nVert);
          end
        end
        PLACING: begin
          posicoesEmbarcacao <= packPos(nAx, nAy, nVert);
          ocupacaoNova       <= packOcc(nAx, nAy, nVert);
          if (!iniciar && btnConfirma) state <= CHECK;
        end
        CHECK: begin
          if (hit) begin
            state <= PLACING;
          end else begin
            state  <= DONE;
            pronto <= 1'b1;
          end
        end
        DONE: begin
          if (iniciar) begin
            state              <= PLACING;
            pronto             <= 1'b0;
            posicoesEmbarcacao <= packPos(nAx, nAy, nVert);
            ocupacaoNova       <= packOcc(nAx, nAy, nVert);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_posicionador_embarcacao.sv
// Scoreboard bench for posicionador_embarcacao: a cell-level reference model predicts every cycle's outputs.
module tb_posicionador_embarcacao;

  localparam int C = 5;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        iniciar = 1'b0;
  logic        btnCima = 1'b0, btnBaixo = 1'b0, btnDireita = 1'b0;
  logic        btnEsquerda = 1'b0, btnGirar = 1'b0, btnConfirma = 1'b0;
  logic [63:0] mapaOcupado = '0;
  logic [63:0] posicoesEmbarcacao, ocupacaoNova;
  logic        valido, pronto, erro;

  posicionador_embarcacao #(.COMPRIMENTO(C)) dut (
    .clk(clk), .reset(reset), .iniciar(iniciar),
    .btnCima(btnCima), .btnBaixo(btnBaixo), .btnDireita(btnDireita),
    .btnEsquerda(btnEsquerda), .btnGirar(btnGirar), .btnConfirma(btnConfirma),
    .mapaOcupado(mapaOcupado), .posicoesEmbarcacao(posicoesEmbarcacao),
    .ocupacaoNova(ocupacaoNova), .valido(valido), .pronto(pronto), .erro(erro)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] pos;
    logic [63:0] occ;
    logic        v, p, e;
  } expect_t;

  expect_t sb[$];
  int checks = 0;
  int fails  = 0;

  // Reference model: phase 0 idle, 1 placing, 2 checking, 3 committed.
  int mPhase = 0;
  int mx = 1, my = 1;
  bit mv = 0;

`ifdef PLACER_ROTATE_EN
  localparam bit ROT = 1'b1;
`else
  localparam bit ROT = 1'b0;
`endif

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit fits(input int x, input int y, input bit v);
    int ex, ey;
    ex = v ? x : x + C - 1;
    ey = v ? y + C - 1 : y;
    return x >= 1 && y >= 1 && ex <= 8 && ey <= 8;
  endfunction

  function automatic logic [63:0] mPos(input int x, input int y, input bit v);
    logic [63:0] r;
    r = 64'(C);
    for (int i = 0; i < C; i++) begin
      r |= 64'(v ? x : x + i) << (3 + 8*i);
      r |= 64'(v ? y + i : y) << (7 + 8*i);
    end
    return r;
  endfunction

  function automatic logic [63:0] mOcc(input int x, input int y, input bit v);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < C; i++)
      r |= 64'(1) << (((v ? y + i : y) - 1) * 8 + ((v ? x : x + i) - 1));
    return r;
  endfunction

  // btns: [0] confirma [1] girar [2] cima [3] baixo [4] direita [5] esquerda
  task automatic step(input bit r, input bit ini, input bit [5:0] btns, input logic [63:0] mapa);
    expect_t e;
    bit moved;
    @(posedge clk);
    #1;
    reset = r; iniciar = ini; mapaOcupado = mapa;
    btnConfirma = btns[0]; btnGirar = btns[1]; btnCima = btns[2];
    btnBaixo = btns[3]; btnDireita = btns[4]; btnEsquerda = btns[5];
    if (r) begin
      mPhase = 0; mx = 1; my = 1; mv = 0;
    end
    e.pos = (mPhase == 0) ? 64'd0 : mPos(mx, my, mv);
    e.occ = (mPhase == 0) ? 64'd0 : mOcc(mx, my, mv);
    e.v   = (mPhase != 0);
    e.p   = (mPhase == 3);
    e.e   = (mPhase == 2) && ((mOcc(mx, my, mv) & mapa) != 0);
    sb.push_back(e);
    if (!r) begin
      case (mPhase)
        0: if (ini) begin mPhase = 1; mx = 1; my = 1; mv = 0; end
        1: begin
          moved = 0;
          if (ini) begin mx = 1; my = 1; mv = 0; end
          else if (btns[0]) mPhase = 2;
          else if (ROT && btns[1]) begin if (fits(mx, my, !mv)) mv = !mv; end
          else if (btns[2]) begin if (fits(mx, my + 1, mv)) my++; end
          else if (btns[3]) begin if (fits(mx, my - 1, mv)) my--; end
          else if (btns[4]) begin if (fits(mx + 1, my, mv)) mx++; end
          else if (btns[5]) begin if (fits(mx - 1, my, mv)) mx--; end
        end
        2: mPhase = e.e ? 1 : 3;
        3: if (ini) begin mPhase = 1; mx = 1; my = 1; mv = 0; end
        default: mPhase = 0;
      endcase
    end
  endtask

  always @(negedge clk) begin
    expect_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("sb_pos", posicoesEmbarcacao, e.pos);
      chk("sb_occ", ocupacaoNova, e.occ);
      chk("sb_valido", 64'(valido), 64'(e.v));
      chk("sb_pronto", 64'(pronto), 64'(e.p));
      chk("sb_erro", 64'(erro), 64'(e.e));
    end
  end

  localparam logic [63:0] VEC0 = 64'h0000_00A8_A098_908D;

  initial begin
    logic [63:0] m;
    bit [5:0] b;
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    @(negedge clk);
    chk("reset_pos", posicoesEmbarcacao, 0);
    chk("reset_occ", ocupacaoNova, 0);
    chk("reset_flags", {61'd0, valido, pronto, erro}, 0);

    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    @(negedge clk);
    chk("start_pos", posicoesEmbarcacao, VEC0);
    chk("start_occ", ocupacaoNova, 64'h1F);
    chk("start_flags", {62'd0, valido, pronto}, 64'd2);

    repeat (3) step(0, 0, 6'b010000, 0);
    step(0, 0, 0, 0);
    @(negedge clk);
    chk("right3_occ", ocupacaoNova, 64'hF8);
    step(0, 0, 6'b010000, 0);
    step(0, 0, 0, 0);
    @(negedge clk);
    chk("right_bound_occ", ocupacaoNova, 64'hF8);

    step(0, 1, 0, 0);
    step(0, 0, 6'b000010, 0);
    step(0, 0, 0, 0);
    @(negedge clk);
`ifdef PLACER_ROTATE_EN
    chk("rotate_pos", posicoesEmbarcacao, 64'h0000_028A_0989_088D);
    chk("rotate_occ", ocupacaoNova, 64'h0000_0001_0101_0101);
`else
    chk("rotate_off_pos", posicoesEmbarcacao, VEC0);
    chk("rotate_off_occ", ocupacaoNova, 64'h1F);
`endif

    step(0, 1, 0, 0);
    step(0, 0, 6'b000001, 64'h4);
    step(0, 0, 0, 64'h4);
    @(negedge clk);
    chk("collide_erro", 64'(erro), 1);
    step(0, 0, 0, 64'h4);
    @(negedge clk);
    chk("collide_erro_once", 64'(erro), 0);
    chk("collide_flags", {62'd0, valido, pronto}, 64'd2);
    step(0, 0, 6'b000100, 64'h4);
    step(0, 0, 6'b000001, 64'h4);
    step(0, 0, 0, 64'h4);
    step(0, 0, 0, 64'h4);
    @(negedge clk);
    chk("commit_pronto", 64'(pronto), 1);
    chk("commit_occ", ocupacaoNova, 64'h1F00);

    step(0, 1, 0, 0);
    step(0, 0, 6'b010100, 0);
    step(0, 0, 0, 0);
    @(negedge clk);
    chk("priority_occ", ocupacaoNova, 64'h1F00);

    #3;
    reset = 1'b1;
    mPhase = 0; mx = 1; my = 1; mv = 0;
    #1;
    chk("async_rst_pos", posicoesEmbarcacao, 0);
    chk("async_rst_occ", ocupacaoNova, 0);
    chk("async_rst_flags", {61'd0, valido, pronto, erro}, 0);
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    @(negedge clk);
    chk("restart_pos", posicoesEmbarcacao, VEC0);

    for (int n = 0; n < 800; n++) begin
      for (int k = 0; k < 6; k++) b[k] = ($urandom_range(0, 99) < 22);
      m = ($urandom_range(0, 1) == 0) ? 64'd0 : ({$urandom, $urandom} & {$urandom, $urandom});
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 99) < 4), b, m);
    end
    step(0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    chk("sb_drained", 64'(sb.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
